best_move_selector: RTL

- Downstream consumer of the weight memory. On `start`, raster-scans all 19x19 cells through the memory's read port (READ / XlocOUT / YlocOUT / dataOUT).
- Unpacks the nine 3-bit threat counters of each cell, computes a weighted score, and tracks the highest-scoring unoccupied cell.
- Reports that cell as the AI's next stone placement to the game controller.
- The controller must hold the memory's WRITE low for the whole scan.

---
 rtl/best_move_selector.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/best_move_selector.sv
// Scans the 19x19 weight memory, scores each cell and reports the best unoccupied one.
// Optional CENTER_TIEBREAK_EN: equal scores prefer the cell closer to the board centre.
module best_move_selector #(
  parameter int unsigned BRD_SIZE = 19,
  parameter logic [7:0]  WGT_W1   = 8'd1,
  parameter logic [7:0]  WGT_W2   = 8'd2,
  parameter logic [7:0]  WGT_W3   = 8'd4,
  parameter logic [7:0]  WGT_W4   = 8'd8,
  parameter logic [7:0]  WGT_W5   = 8'd16,
  parameter logic [7:0]  WGT_T1   = 8'd3,
  parameter logic [7:0]  WGT_T2   = 8'd6,
  parameter logic [7:0]  WGT_T3   = 8'd12,
  parameter logic [7:0]  WGT_T    = 8'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        READ,
  output logic [4:0]  XlocOUT,
  output logic [4:0]  YlocOUT,
  input  logic [26:0] dataIN,
  input  logic        occupied,
  output logic        busy,
  output logic        done,
  output logic [4:0]  bestX,
  output logic [4:0]  bestY,
  output logic [15:0] bestScore,
  output logic        noMove
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [4:0] LAST = 5'(BRD_SIZE - 1);

  logic [1:0]  r_state;
  logic [4:0]  r_x;
  logic [4:0]  r_y;
  logic        r_pv;
  logic        r_pocc;
  logic [4:0]  r_px;
  logic [4:0]  r_py;
  logic        r_found;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_bx;
  logic [4:0]  r_by;
  logic [15:0] r_bs;
  logic        r_nomove;

  logic [15:0] w_score;
  logic        w_better;
  logic        w_update;

  function automatic logic [15:0] term(input logic [2:0] f, input logic [7:0] w);
    return 16'(f) * 16'(w);
  endfunction

  always_comb begin
    w_score = term(dataIN[2:0],   WGT_W1) + term(dataIN[5:3],   WGT_W2)
            + term(dataIN[8:6],   WGT_W3) + term(dataIN[11:9],  WGT_W4)
            + term(dataIN[14:12], WGT_W5) + term(dataIN[17:15], WGT_T1)
            + term(dataIN[20:18], WGT_T2) + term(dataIN[23:21], WGT_T3)
            + term(dataIN[26:24], WGT_T);
  end

`ifdef CENTER_TIEBREAK_EN
  localparam logic [4:0] CTR = 5'((BRD_SIZE - 1) / 2);

  logic [4:0] r_bdist;
  logic [4:0] w_dx;
  logic [4:0] w_dy;
  logic [4:0] w_dist;

  always_comb begin
    w_dx     = (r_px >= CTR) ? (r_px - CTR) : (CTR - r_px);
    w_dy     = (r_py >= CTR) ? (r_py - CTR) : (CTR - r_py);
    w_dist   = w_dx + w_dy;
    w_better = (w_score > r_bs) || ((w_score == r_bs) && (w_dist < r_bdist));
  end
`else
  always_comb begin
    w_better = (w_score > r_bs);
  end
`endif

  // r_pv marks a cell issued last cycle whose data is now on dataIN
  always_comb begin
    w_update = r_pv && !r_pocc && (!r_found || w_better);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_pv     <= 1'b0;
      r_pocc   <= 1'b0;
      r_px     <= '0;
      r_py     <= '0;
      r_found  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bx     <= '0;
      r_by     <= '0;
      r_bs     <= '0;
      r_nomove <= 1'b0;
`ifdef CENTER_TIEBREAK_EN
      r_bdist  <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x  <= '0;
          r_y  <= '0;
          r_pv <= 1'b0;
          if (start) begin
            r_state  <= S_SCAN;
            r_busy   <= 1'b1;
            r_found  <= 1'b0;
            r_bx     <= '0;
            r_by     <= '0;
            r_bs     <= '0;
            r_nomove <= 1'b0;
`ifdef CENTER_TIEBREAK_EN
            r_bdist  <= '0;
`endif
          end
        end
        S_SCAN: begin
          r_pv   <= 1'b1;
          r_pocc <= occupied;
          r_px   <= r_x;
          r_py   <= r_y;
          if (r_x == LAST) begin
            r_x <= '0;
            if (r_y == LAST) begin
              r_y     <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_y <= r_y + 5'd1;
            end
          end else begin
            r_x <= r_x + 5'd1;
          end
        end
        S_DRAIN: begin
          r_pv     <= 1'b0;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          // last cell's compare lands this same edge, so fold it into noMove
          r_nomove <= !(r_found || w_update);
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_update) begin
        r_found <= 1'b1;
        r_bx    <= r_px;
        r_by    <= r_py;
        r_bs    <= w_score;
`ifdef CENTER_TIEBREAK_EN
        r_bdist <= w_dist;
`endif
      end
    end
  end

  assign READ      = (r_state == S_SCAN);
  assign XlocOUT   = r_x;
  assign YlocOUT   = r_y;
  assign busy      = r_busy;
  assign done      = r_done;
  assign bestX     = r_bx;
  assign bestY     = r_by;
  assign bestScore = r_bs;
  assign noMove    = r_nomove;

endmodule
